// File: rtl/i2c_target_datapath.sv
// i2c_target_datapath: 7-bit I2C target byte engine with START/STOP detection, ACK/NACK and TX/RX shifting.
// Optional SCL stretching while waiting for TX data: define I2C_TARGET_CLOCK_STRETCH_EN.
module i2c_target_datapath (
  input  logic       i2c_core_clock_i,
  input  logic       reset_bit_n_i,
  input  logic       scl_i,
  input  logic       sda_i,
  input  logic [6:0] own_addr_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       sda_o,
  output logic       scl_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       tx_req_o,
  output logic       busy_o,
  output logic       rw_o,
  output logic       nack_o,
  output logic       stop_o
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP} state_t;
  state_t state_q, state_d;
  logic [2:0] scl_q, sda_q;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, sh_in, rx_q, rx_d, load_byte;
  logic sda_q_o, sda_d, rw_q, rw_d, busy_q, busy_d, wait_q, wait_d;
  logic rxv_q, rxv_d, txr_q, txr_d, nack_q, nack_d, stop_q, stop_d;
  logic scl_rise, scl_fall, start_det, stop_det, load, load_ok;
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
  assign sh_in     = {sh_q[6:0], sda_q[1]};
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
  logic scl_o_q;
  assign load_ok   = tx_valid_i;
  assign load_byte = tx_data_i;
  assign scl_o     = scl_o_q;
  // Release lags the load by one clock so the first data bit is settled first.
  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_n_i)
    if (!reset_bit_n_i) scl_o_q <= 1'b1;
    else scl_o_q <= ~wait_q;
`else
  assign load_ok   = 1'b1;
  assign load_byte = tx_valid_i ? tx_data_i : 8'hFF;
  assign scl_o     = 1'b1;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    sda_d   = sda_q_o;
    rw_d    = rw_q;
    busy_d  = busy_q;
    wait_d  = wait_q;
    rxv_d   = 1'b0;
    txr_d   = 1'b0;
    nack_d  = 1'b0;
    stop_d  = 1'b0;
    load    = 1'b0;
    if (stop_det) begin
      state_d = IDLE;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
      stop_d  = 1'b1;
      wait_d  = 1'b0;
    end else if (start_det) begin
      state_d = ADDR;
      cnt_d   = 4'd0;
      busy_d  = 1'b1;
      sda_d   = 1'b1;
      wait_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          sh_d  = sh_in;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            state_d = (sh_in[7:1] == own_addr_i) ? ADDR_ACK : WAIT_STOP;
            rw_d    = (sh_in[7:1] == own_addr_i) ? sh_in[0] : rw_q;
          end
        end
        // First falling edge starts the ACK drive, the second ends it.
        ADDR_ACK, RX_ACK: if (scl_fall) begin
          sda_d = sda_q_o ? 1'b0 : 1'b1;
          cnt_d = 4'd0;
          if (!sda_q_o) begin
            state_d = RX_DATA;
            load    = (state_q == ADDR_ACK) && rw_q;
          end
        end
        RX_DATA: if (scl_rise) begin
          sh_d  = sh_in;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            rx_d    = sh_in;
            rxv_d   = 1'b1;
            state_d = RX_ACK;
          end
        end
        TX_DATA: if (wait_q) load = 1'b1;
          else if (scl_rise) cnt_d = cnt_q + 4'd1;
          else if (scl_fall) begin
            sda_d   = (cnt_q == 4'd8) ? 1'b1 : sh_q[6];
            sh_d    = {sh_q[6:0], 1'b0};
            state_d = (cnt_q == 4'd8) ? TX_ACK : TX_DATA;
          end
        TX_ACK: if (scl_rise && sda_q[1]) begin
          nack_d  = 1'b1;
          state_d = WAIT_STOP;
        end else if (scl_fall) load = 1'b1;
        default: ;
      endcase
      if (load) begin
        state_d = TX_DATA;
        wait_d  = ~load_ok;
        sda_d   = load_ok ? load_byte[7] : 1'b1;
        sh_d    = load_ok ? load_byte : sh_q;
        txr_d   = load_ok;
        cnt_d   = 4'd0;
      end
    end
  end
  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_n_i)
    if (!reset_bit_n_i) begin
      state_q <= IDLE;
      scl_q   <= 3'b111;
      sda_q   <= 3'b111;
      cnt_q   <= 4'd0;
      sh_q    <= 8'd0;
      rx_q    <= 8'd0;
      sda_q_o <= 1'b1;
      rw_q    <= 1'b0;
      busy_q  <= 1'b0;
      wait_q  <= 1'b0;
      rxv_q   <= 1'b0;
      txr_q   <= 1'b0;
      nack_q  <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      scl_q   <= {scl_q[1:0], scl_i};
      sda_q   <= {sda_q[1:0], sda_i};
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      sda_q_o <= sda_d;
      rw_q    <= rw_d;
      busy_q  <= busy_d;
      wait_q  <= wait_d;
      rxv_q   <= rxv_d;
      txr_q   <= txr_d;
      nack_q  <= nack_d;
      stop_q  <= stop_d;
    end
  assign sda_o      = sda_q_o;
  assign rx_data_o  = rx_q;
  assign rx_valid_o = rxv_q;
  assign tx_req_o   = txr_q;
  assign busy_o     = busy_q;
  assign rw_o       = rw_q;
  assign nack_o     = nack_q;
  assign stop_o     = stop_q;
endmodule

// File: tb/tb_i2c_target_datapath.sv
// tb_i2c_target_datapath: directed I2C master transactions against i2c_target_datapath on a wired-AND bus.
module tb_i2c_target_datapath;
  logic clk = 1'b0, rst_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1, tx_valid = 1'b0;
  logic [6:0] own_addr = 7'h50;
  logic [7:0] tx_data = 8'h00, rx_data;
  logic sda_o, scl_o, rx_valid, tx_req, busy, rw, nack, stop;
  logic scl_bus, sda_bus;
  int total = 0, bad = 0;
  int rxv_n = 0, txr_n = 0, nack_n = 0, stop_n = 0;
  assign scl_bus = scl_m & scl_o;
  assign sda_bus = sda_m & sda_o;
  always #5 clk = ~clk;
  i2c_target_datapath dut (
    .i2c_core_clock_i(clk), .reset_bit_n_i(rst_n), .scl_i(scl_bus), .sda_i(sda_bus),
    .own_addr_i(own_addr), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .sda_o(sda_o), .scl_o(scl_o), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .tx_req_o(tx_req), .busy_o(busy), .rw_o(rw), .nack_o(nack), .stop_o(stop));
  always @(posedge clk) begin
    if (rx_valid) rxv_n++;
    if (tx_req) txr_n++;
    if (nack) nack_n++;
    if (stop) stop_n++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic i2c_bit(input logic b, output logic o);
    int n;
    sda_m = b;
    repeat (6) @(negedge clk);
    scl_m = 1'b1;
    n = 0;
    while (scl_bus !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("scl_timeout", 32'(scl_bus), 32'd1);
    repeat (6) @(negedge clk);
    o = sda_o;
    scl_m = 1'b0;
    repeat (6) @(negedge clk);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic ack_m, output logic [8:0] o);
    for (int i = 0; i < 8; i++) i2c_bit(b[7-i], o[8-i]);
    i2c_bit(ack_m, o[0]);
  endtask
  task automatic i2c_start();
    sda_m = 1'b1;
    repeat (3) @(negedge clk);
    scl_m = 1'b1;
    repeat (6) @(negedge clk);
    sda_m = 1'b0;
    repeat (6) @(negedge clk);
    scl_m = 1'b0;
    repeat (6) @(negedge clk);
  endtask
  task automatic i2c_stop();
    sda_m = 1'b0;
    repeat (6) @(negedge clk);
    scl_m = 1'b1;
    repeat (6) @(negedge clk);
    sda_m = 1'b1;
    repeat (6) @(negedge clk);
  endtask
  initial begin
    logic [8:0] o;
    logic b;
    int base_rxv, base_txr, base_nack, base_stop, lows;
    repeat (3) @(negedge clk);
    chk("rst_sda", 32'(sda_o), 32'd1);
    chk("rst_scl", 32'(scl_o), 32'd1);
    chk("rst_rxdata", 32'(rx_data), 32'h00);
    chk("rst_flags", {rx_valid, tx_req, busy, rw, nack, stop}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    // write 0xA0, 0x3C, STOP
    base_rxv = rxv_n; base_stop = stop_n;
    i2c_start();
    chk("wr_busy", 32'(busy), 32'd1);
    send_byte(8'hA0, 1'b1, o);
    chk("wr_addr_ack", 32'(o), 32'h1FE);
    chk("wr_rw", 32'(rw), 32'd0);
    send_byte(8'h3C, 1'b1, o);
    chk("wr_data_ack", 32'(o), 32'h1FE);
    chk("wr_rxdata", 32'(rx_data), 32'h3C);
    chk("wr_rxv_cnt", 32'(rxv_n - base_rxv), 32'd1);
    i2c_stop();
    chk("wr_stop_cnt", 32'(stop_n - base_stop), 32'd1);
    chk("wr_busy_off", 32'(busy), 32'd0);
    // non-matching address
    base_rxv = rxv_n;
    i2c_start();
    send_byte(8'hA2, 1'b1, o);
    chk("nm_sda", 32'(o), 32'h1FF);
    chk("nm_state", 32'(dut.state_q), 32'd7);
    chk("nm_rxv_cnt", 32'(rxv_n - base_rxv), 32'd0);
    i2c_stop();
    // read 0x96 with master NACK
    tx_data = 8'h96; tx_valid = 1'b1;
    base_txr = txr_n; base_nack = nack_n;
    i2c_start();
    send_byte(8'hA1, 1'b1, o);
    chk("rd_addr_ack", 32'(o), 32'h1FE);
    chk("rd_rw", 32'(rw), 32'd1);
    send_byte(8'hFF, 1'b1, o);
    chk("rd_bits", 32'(o), 32'h12D);
    chk("rd_txreq_cnt", 32'(txr_n - base_txr), 32'd1);
    chk("rd_nack_cnt", 32'(nack_n - base_nack), 32'd1);
    chk("rd_sda_rel", 32'(sda_o), 32'd1);
    i2c_stop();
    tx_valid = 1'b0;
    // repeated START after 4 data bits
    base_rxv = rxv_n;
    i2c_start();
    send_byte(8'hA0, 1'b1, o);
    for (int i = 0; i < 4; i++) i2c_bit(1'b0, b);
    i2c_start();
    chk("rs_state", 32'(dut.state_q), 32'd1);
    chk("rs_cnt", 32'(dut.cnt_q), 32'd0);
    chk("rs_rxv_cnt", 32'(rxv_n - base_rxv), 32'd0);
    i2c_stop();
    // reset during ADDR_ACK
    i2c_start();
    for (int i = 0; i < 8; i++) i2c_bit(i == 0 || i == 2, b);
    chk("ra_ack_drv", 32'(sda_o), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ra_sda", 32'(sda_o), 32'd1);
    chk("ra_scl", 32'(scl_o), 32'd1);
    chk("ra_rxdata", 32'(rx_data), 32'h3C & 32'h0);
    chk("ra_flags", {rx_valid, tx_req, busy, rw, nack, stop}, 32'd0);
    chk("ra_state", 32'(dut.state_q), 32'd0);
    @(negedge clk);
    sda_m = 1'b1;
    scl_m = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    // read with TX data late by 20 clocks
    base_txr = txr_n;
    i2c_start();
    send_byte(8'hA1, 1'b1, o);
    chk("st_addr_ack", 32'(o), 32'h1FE);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (scl_o === 1'b0) lows++;
    end
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
    chk("st_scl_low", 32'(lows), 32'd20);
    chk("st_no_req", 32'(txr_n - base_txr), 32'd0);
    tx_data = 8'h5A; tx_valid = 1'b1;
    send_byte(8'hFF, 1'b1, o);
    chk("st_bits", 32'(o), 32'h0B5);
`else
    chk("st_scl_low", 32'(lows), 32'd0);
    chk("st_req", 32'(txr_n - base_txr), 32'd1);
    tx_data = 8'h5A; tx_valid = 1'b1;
    send_byte(8'hFF, 1'b1, o);
    chk("st_bits", 32'(o), 32'h1FF);
`endif
    i2c_stop();
    tx_valid = 1'b0;
    chk("st_busy_off", 32'(busy), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
